ex_muldiv_ctrl: RTL and testbench
=================================

// Module: ex_muldiv_ctrl
// PURPOSE
//  Sequencer for an iterative 32-bit multiply/divide unit attached to the EX stage; owns HI/LO.
//  Accepts MULT/MULTU/DIV/DIVU from ID/EX and runs one iteration per cycle.
//  Serves MFHI/MFLO/MTHI/MTLO and drives the stall request to the pipeline's hazard logic.
//  Operands arrive already forwarded (the same A/B the ALU sees).
// PARAMETERS
//  WIDTH  32  operand width; iteration count per op = WIDTH
// PORTS
//  clk           in   1      pipeline clock
//  rst           in   1      synchronous, active-high reset
//  MdOp_ex       in   3      op in EX: 0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI/MTLO
//  MdSelLo_ex    in   1      for op 7: 1 = MTLO, 0 = MTHI
//  Flush_ex      in   1      EX instruction is squashed; treat MdOp_ex as NONE
//  A_ex          in   WIDTH  forwarded rs data
//  B_ex          in   WIDTH  forwarded rt data
//  Stall_md      out  1      freeze PC, IF/ID and ID/EX; inject a bubble into EX/MEM
//  Busy_md       out  1      state != IDLE
//  MdResult_ex   out  WIDTH  HI (MFHI) or LO (MFLO); 0 otherwise
//  Hi, Lo        out  WIDTH  architectural HI/LO (debug/observe)
// BEHAVIOUR
//  - Reset: state=IDLE, Hi=Lo=0, counter=0, Stall_md=0, Busy_md=0.
//  - Reset mid-op: the op is abandoned and HI/LO are cleared.
//  - Valid op = MdOp_ex!=0 && !Flush_ex.
//  - Stall_md = valid op && state!=IDLE (combinational).
//    - The pipeline re-presents the held op every cycle until it is accepted.
//  - FSM states: IDLE, MUL, DIV, DONE.
//    - IDLE + valid MULT/MULTU -> MUL. Latch operands; signed ops latch |A|, |B| and record the result signs.
//    - IDLE + valid DIV/DIVU -> DIV. Latch operands the same way.
//    - MUL/DIV: one shift-add (MUL) or restoring-subtract (DIV) step per cycle.
//      After WIDTH steps -> DONE.
//    - DONE: apply sign correction and write HI/LO at the clock edge -> IDLE.
//  - Timing: op accepted at cycle 0, MUL/DIV at cycles 1..WIDTH, DONE at WIDTH+1.
//    New HI/LO are visible from cycle WIDTH+2.
//  - MULT/DIV issue does not stall the pipeline. Only a following md op (including MF/MT) stalls while Busy_md.
//  - MUL results: {Hi,Lo} = 64-bit product. Signed: negate if sign(A)^sign(B).
//  - DIV results: Lo = quotient, Hi = remainder.
//    - Signed: quotient negated if sign(A)^sign(B); remainder takes sign of A.
//    - B==0: Lo=all-ones, Hi=A. No exception raised.
//    - Signed 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
//  - MFHI/MFLO in IDLE: MdResult_ex = Hi/Lo combinationally. The normal WB path writes rd.
//  - MTHI/MTLO in IDLE: Hi/Lo <= A_ex at the clock edge.
//    - MF of the same register in the next cycle sees the new value.
//  - Flush_ex asserted while Busy_md does not abort the running op; the op was committed when accepted.
//  - No simultaneous HI/LO writers exist: MT is stalled while busy, and DONE is the only other writer.
// STRUCTURE
//  - Shared package md_pkg:
//    - MdOp encodings (MD_NONE..MD_MT)
//    - state enum (S_IDLE, S_MUL, S_DIV, S_DONE)
//    - WIDTH default
//  - Sub-module md_iter_core:
//    - 2*WIDTH accumulator/remainder register and the per-step add/subtract-shift
//    - 6-bit iteration counter and done flag
//  - ex_muldiv_ctrl keeps the FSM, sign handling, HI/LO registers and stall logic.
// TESTING
//  1. MULT A=0xFFFFFFFE(-2),B=3 at cycle 0, MFLO at cycle 1
//     -> Stall_md=1 cycles 1..33; MdResult_ex=0xFFFFFFFA, Hi=0xFFFFFFFF at cycle 34.
//  2. MULTU A=0xFFFFFFFF,B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001 after 34 cycles; no stall with no md follower.
//  3. DIV A=-7,B=2 -> Lo=0xFFFFFFFD(-3), Hi=0xFFFFFFFF(-1).
//     DIVU A=7,B=0 -> Lo=0xFFFFFFFF, Hi=7.
//  4. DIV A=0x80000000,B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
//  5. MTHI 0x1234 then MFHI next cycle -> MdResult_ex=0x1234, no stall.
//     MTLO issued while Busy_md -> stalls until IDLE, then Lo written.
//  6. rst asserted at cycle 10 of a MULT -> next cycle IDLE, Hi=Lo=0, Stall_md=0.
//     Flush_ex with a DIV in IDLE -> no start, Busy_md stays 0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
package md_pkg;

    localparam int MD_WIDTH = 32;

    // Op code carried from ID/EX alongside the ALU operands.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MFHI  = 3'd5,
        MD_MFLO  = 3'd6,
        MD_MT    = 3'd7
    } md_op_e;

    // Sequencer state; anything other than S_IDLE means the unit is busy.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    // Signed ops work on magnitudes and fix the sign up at the end.
    function automatic logic op_is_signed(md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative datapath: one shift-add multiply step or one restoring divide
// step per cycle on a 2*WIDTH register, plus the step counter.
// Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, quotient}.
module md_iter_core
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               start_div,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic               done
);

    logic [WIDTH-1:0] divisor;
    logic             mode_div;
    logic [5:0]       count;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    // Per-step arithmetic: conditional add for multiply, trial subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : {(WIDTH+1){1'b0}});
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff      = rem_shift - {1'b0, divisor};
    end

    // done marks the step that completes the operation.
    assign done = step && (count == 6'(WIDTH-1));

    // Accumulator, divisor and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            divisor  <= '0;
            mode_div <= 1'b0;
            count    <= '0;
        end else if (start) begin
            acc      <= {{WIDTH{1'b0}}, a};
            divisor  <= b;
            mode_div <= start_div;
            count    <= '0;
        end else if (step) begin
            count <= count + 6'd1;
            if (mode_div) begin
                // A non-negative trial difference means the divisor fits: keep it, quotient bit 1.
                if (!diff[WIDTH])
                    acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc <= {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, runs the iterative core,
// serves MF/MT and requests pipeline stalls for md ops that arrive while busy.
// Handshake: an md op is valid when MdOp_ex != NONE and not flushed; it is
// accepted in the cycle it is valid with the unit idle. While the unit is
// busy a valid op raises Stall_md and the pipeline re-presents it each cycle.
module ex_muldiv_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       MdOp_ex,
    input  logic             MdSelLo_ex,
    input  logic             Flush_ex,
    input  logic [WIDTH-1:0] A_ex,
    input  logic [WIDTH-1:0] B_ex,
    output logic             Stall_md,
    output logic             Busy_md,
    output logic [WIDTH-1:0] MdResult_ex,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    md_op_e    op;
    md_state_e state, state_next;
    logic      valid;
    logic      start, start_div, step, hilo_wr, mt_wr;
    logic      core_done;
    logic [2*WIDTH-1:0] acc;

    logic      sign_a, sign_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic      neg_res, neg_rem, b_zero, op_div;

    logic [2*WIDTH-1:0] mul_fix;
    logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

    assign op    = md_op_e'(MdOp_ex);
    assign valid = (op != MD_NONE) && !Flush_ex;

    assign Busy_md  = (state != S_IDLE);
    assign Stall_md = valid && (state != S_IDLE);

    // Signed ops hand magnitudes to the core; signs are recorded at accept.
    always_comb begin
        sign_a = op_is_signed(op) && A_ex[WIDTH-1];
        sign_b = op_is_signed(op) && B_ex[WIDTH-1];
        a_mag  = sign_a ? (~A_ex + 1'b1) : A_ex;
        b_mag  = sign_b ? (~B_ex + 1'b1) : B_ex;
    end

    // Next-state, core control and MF result mux.
    always_comb begin
        state_next  = state;
        start       = 1'b0;
        start_div   = 1'b0;
        step        = 1'b0;
        hilo_wr     = 1'b0;
        mt_wr       = 1'b0;
        MdResult_ex = '0;
        case (state)
            S_IDLE: begin
                if (valid) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            start      = 1'b1;
                            state_next = S_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            start      = 1'b1;
                            start_div  = 1'b1;
                            state_next = S_DIV;
                        end
                        MD_MFHI: MdResult_ex = Hi;
                        MD_MFLO: MdResult_ex = Lo;
                        MD_MT:   mt_wr = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                step = 1'b1;
                if (core_done)
                    state_next = S_DONE;
            end
            S_DONE: begin
                hilo_wr    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Sign correction of the raw core result. A zero divisor keeps the
    // all-ones quotient; the remainder always takes the dividend's sign.
    always_comb begin
        mul_fix = neg_res ? (~acc + 1'b1) : acc;
        quo     = acc[WIDTH-1:0];
        rem     = acc[2*WIDTH-1:WIDTH];
        if (op_div) begin
            fin_lo = (neg_res && !b_zero) ? (~quo + 1'b1) : quo;
            fin_hi = neg_rem ? (~rem + 1'b1) : rem;
        end else begin
            fin_lo = mul_fix[WIDTH-1:0];
            fin_hi = mul_fix[2*WIDTH-1:WIDTH];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Sign/kind flags captured when an op is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            op_div  <= 1'b0;
        end else if (start) begin
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            b_zero  <= (B_ex == '0);
            op_div  <= start_div;
        end
    end

    // HI/LO: written by DONE or by MTHI/MTLO; the two never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            Hi <= '0;
            Lo <= '0;
        end else if (hilo_wr) begin
            Hi <= fin_hi;
            Lo <= fin_lo;
        end else if (mt_wr) begin
            if (MdSelLo_ex)
                Lo <= A_ex;
            else
                Hi <= A_ex;
        end
    end

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_div (start_div),
        .step      (step),
        .a         (a_mag),
        .b         (b_mag),
        .acc       (acc),
        .done      (core_done)
    );

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: vector table plus random ops through a scoreboard,
// then hand-written sequences for stall, MT/MF, reset and flush corners.
module tb_ex_muldiv_ctrl;

    localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2,
                           OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MFHI = 3'd5,
                           OP_MFLO = 3'd6, OP_MT = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  md_op = OP_NONE;
    logic        sel_lo = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        stall, busy;
    logic [31:0] result, hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    ex_muldiv_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .MdOp_ex     (md_op),
        .MdSelLo_ex  (sel_lo),
        .Flush_ex    (flush),
        .A_ex        (a_in),
        .B_ex        (b_in),
        .Stall_md    (stall),
        .Busy_md     (busy),
        .MdResult_ex (result),
        .Hi          (hi),
        .Lo          (lo)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model of HI/LO after an arithmetic op.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     ia, ib;
        logic [63:0] r;
        r = '0;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                r  = 64'(sa * sb);
            end
            OP_MULTU: r = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                ia = int'(a);
                ib = int'(b);
                if (b == 32'd0)
                    r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else
                    r = {32'(ia % ib), 32'(ia / ib)};
            end
            OP_DIVU: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFF_FFFF};
                else
                    r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Issue one arithmetic op with no md follower; scoreboard result, latency, no stall.
    task automatic run_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp, input int idx);
        int n;
        logic stall_seen;
        logic [63:0] want;
        md_op = op;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        check($sformatf("issue_stall[%0d]", idx), 64'(stall), 64'd0);
        exp_q.push_back(exp);
        tick();
        md_op = OP_NONE;
        a_in  = $urandom;
        b_in  = $urandom;
        n = 0;
        stall_seen = 1'b0;
        @(negedge clk);
        while (busy && n < 60) begin
            n++;
            if (stall) stall_seen = 1'b1;
            tick();
            @(negedge clk);
        end
        check($sformatf("busy_cycles[%0d]", idx), 64'(n), 64'd33);
        check($sformatf("follower_stall[%0d]", idx), 64'(stall_seen), 64'd0);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check($sformatf("hilo[%0d]", idx), {hi, lo}, want);
        end
        tick();
        md_op = OP_MFHI;
        @(negedge clk);
        check($sformatf("mfhi[%0d]", idx), 64'(result), 64'(exp[63:32]));
        tick();
        md_op = OP_MFLO;
        @(negedge clk);
        check($sformatf("mflo[%0d]", idx), 64'(result), 64'(exp[31:0]));
        tick();
        md_op = OP_NONE;
    endtask

    initial begin
        int n;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        64'hFFFF_FFFF_FFFF_FFFA};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'd7,         32'd0,        64'h0000_0007_FFFF_FFFF};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[5] = '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003};
        vecs[6] = '{OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[7] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,        64'hFFFF_FFF9_FFFF_FFFF};
        vecs[8] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h10,       64'h0000_000F_0FFF_FFFF};
        vecs[9] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

        // Reset.
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_result", 64'(result), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Vector table.
        for (int i = 0; i < 10; i++)
            run_arith(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, i);

        // Random ops against the model.
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) rb = 32'($urandom_range(1, 255));
            run_arith(rop, ra, rb, model(rop, ra, rb), 100 + i);
        end

        // MULT -2*3 followed by MFLO: stalled through DONE, result at cycle 34.
        md_op = OP_MULT;
        a_in  = 32'hFFFF_FFFE;
        b_in  = 32'd3;
        tick();
        md_op = OP_MFLO;
        n = 0;
        @(negedge clk);
        while (stall && n < 60) begin
            n++;
            tick();
            @(negedge clk);
        end
        check("mflo_stall_cycles", 64'(n), 64'd33);
        check("mflo_after_mult", 64'(result), 64'hFFFF_FFFA);
        check("hi_after_mult", 64'(hi), 64'hFFFF_FFFF);
        tick();
        md_op = OP_NONE;

        // MTHI then MFHI next cycle.
        md_op  = OP_MT;
        sel_lo = 1'b0;
        a_in   = 32'h0000_1234;
        @(negedge clk);
        check("mthi_stall", 64'(stall), 64'd0);
        tick();
        md_op = OP_MFHI;
        a_in  = 32'h0;
        @(negedge clk);
        check("mfhi_after_mthi", 64'(result), 64'h1234);
        check("mfhi_stall", 64'(stall), 64'd0);
        tick();

        // MTLO while busy: stalls until idle, then Lo written.
        md_op = OP_MULTU;
        a_in  = 32'd2;
        b_in  = 32'd3;
        tick();
        md_op  = OP_MT;
        sel_lo = 1'b1;
        a_in   = 32'h0000_ABCD;
        n = 0;
        @(negedge clk);
        while (stall && n < 60) begin
            n++;
            tick();
            @(negedge clk);
        end
        check("mtlo_stall_cycles", 64'(n), 64'd33);
        check("lo_before_mtlo", 64'(lo), 64'd6);
        tick();
        md_op  = OP_NONE;
        sel_lo = 1'b0;
        @(negedge clk);
        check("mtlo_written", {hi, lo}, 64'h0000_0000_0000_ABCD);
        tick();

        // Reset in the middle of a MULT.
        md_op = OP_MULT;
        a_in  = 32'd5;
        b_in  = 32'd5;
        tick();
        md_op = OP_NONE;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        md_op = OP_MFHI;
        @(negedge clk);
        check("midop_rst_busy", 64'(busy), 64'd0);
        check("midop_rst_stall", 64'(stall), 64'd0);
        check("midop_rst_hilo", {hi, lo}, 64'd0);
        tick();
        md_op = OP_NONE;
        repeat (40) tick();
        @(negedge clk);
        check("midop_rst_no_write", {hi, lo}, 64'd0);

        // Flushed DIV in idle does not start.
        tick();
        md_op = OP_DIV;
        flush = 1'b1;
        a_in  = 32'd100;
        b_in  = 32'd7;
        @(negedge clk);
        check("flush_idle_stall", 64'(stall), 64'd0);
        tick();
        md_op = OP_NONE;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", 64'(busy), 64'd0);

        // Flush while busy does not abort the running op.
        tick();
        md_op = OP_DIVU;
        a_in  = 32'd100;
        b_in  = 32'd7;
        tick();
        md_op = OP_DIV;
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy_stall", 64'(stall), 64'd0);
        check("flush_busy_busy", 64'(busy), 64'd1);
        tick();
        md_op = OP_NONE;
        flush = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            n++;
            tick();
            @(negedge clk);
        end
        check("flush_busy_done", 64'(n), 64'd32);
        check("flush_busy_hilo", {hi, lo}, {32'd2, 32'd14});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
